// File: rtl/cc_lives_manager.sv
// Lives bookkeeping for the frog game: PLAY / GRACE / OVER FSM with registered outputs.
// Optional extra-life input is compiled in when LIVES_BONUS_EN is defined.
module cc_lives_manager #(
    parameter int LIVES_COUNTER_DATAWIDTH = 3,
    parameter int LIVES_INIT              = 3,
    parameter int LIVES_MAX               = 7,
    parameter int LIVES_LOW_THRESHOLD     = 1,
    parameter int GRACE_CYCLES            = 16,
    parameter int GRACE_DATAWIDTH         = 5
) (
    input  logic                               CC_LIVES_MANAGER_CLOCK_50,
    input  logic                               CC_LIVES_MANAGER_RESET_InHigh,
    input  logic                               CC_LIVES_MANAGER_restart_InHigh,
    input  logic                               CC_LIVES_MANAGER_death_InHigh,
`ifdef LIVES_BONUS_EN
    input  logic                               CC_LIVES_MANAGER_bonus_InHigh,
`endif
    output logic [LIVES_COUNTER_DATAWIDTH-1:0] CC_LIVES_MANAGER_lives_Out,
    output logic                               CC_LIVES_MANAGER_gameover_OutHigh,
    output logic                               CC_LIVES_MANAGER_low_OutHigh,
    output logic                               CC_LIVES_MANAGER_grace_OutHigh,
    output logic                               CC_LIVES_MANAGER_lifelost_OutHigh
);

    localparam int W  = LIVES_COUNTER_DATAWIDTH;
    localparam int GW = GRACE_DATAWIDTH;

    // Initial load is clamped to the ceiling so an illegal parameter set cannot exceed it.
    localparam int LIVES_LOAD_INT = (LIVES_INIT > LIVES_MAX) ? LIVES_MAX : LIVES_INIT;

    localparam logic [W-1:0]  LIVES_LOAD = W'(LIVES_LOAD_INT);
    localparam logic [W-1:0]  LIVES_TOP  = W'(LIVES_MAX);
    localparam logic [W-1:0]  LOW_LEVEL  = W'(LIVES_LOW_THRESHOLD);
    localparam logic [GW-1:0] GRACE_LOAD = GW'(GRACE_CYCLES);
    localparam logic          LOW_AT_RESET = (LIVES_LOAD != '0) && (LIVES_LOAD <= LOW_LEVEL);

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        GRACE = 2'd1,
        OVER  = 2'd2
    } stateType;

    stateType       state;
    stateType       stateNext;
    logic [W-1:0]   lives;
    logic [W-1:0]   livesNext;
    logic [W-1:0]   livesBumped;
    logic [GW-1:0]  graceCount;
    logic [GW-1:0]  graceCountNext;
    logic           lifelostNext;
    logic           bonus;

`ifdef LIVES_BONUS_EN
    assign bonus       = CC_LIVES_MANAGER_bonus_InHigh;
    assign livesBumped = (lives >= LIVES_TOP) ? lives : lives + W'(1);
`else
    assign bonus       = 1'b0;
    assign livesBumped = lives;
`endif

    always_comb begin
        stateNext      = state;
        livesNext      = lives;
        graceCountNext = graceCount;
        lifelostNext   = 1'b0;

        unique case (state)
            PLAY: begin
                if (CC_LIVES_MANAGER_death_InHigh) begin
                    lifelostNext = 1'b1;
                    // A bonus arriving with the death cancels the decrement; lives stays >= 1.
                    if (bonus) begin
                        stateNext      = GRACE;
                        graceCountNext = GRACE_LOAD;
                    end else begin
                        livesNext = lives - W'(1);
                        if (lives <= W'(1)) begin
                            stateNext      = OVER;
                            graceCountNext = '0;
                        end else begin
                            stateNext      = GRACE;
                            graceCountNext = GRACE_LOAD;
                        end
                    end
                end else if (bonus) begin
                    livesNext = livesBumped;
                end
            end
            GRACE: begin
                if (bonus) begin
                    livesNext = livesBumped;
                end
                if (graceCount <= GW'(1)) begin
                    stateNext      = PLAY;
                    graceCountNext = '0;
                end else begin
                    graceCountNext = graceCount - GW'(1);
                end
            end
            OVER: begin
                livesNext      = '0;
                graceCountNext = '0;
            end
            default: begin
                stateNext      = PLAY;
                livesNext      = LIVES_LOAD;
                graceCountNext = '0;
            end
        endcase

        if (CC_LIVES_MANAGER_restart_InHigh) begin
            stateNext      = PLAY;
            livesNext      = LIVES_LOAD;
            graceCountNext = '0;
            lifelostNext   = 1'b0;
        end
    end

    always_ff @(posedge CC_LIVES_MANAGER_CLOCK_50) begin
        if (CC_LIVES_MANAGER_RESET_InHigh) begin
            state                             <= PLAY;
            lives                             <= LIVES_LOAD;
            graceCount                        <= '0;
            CC_LIVES_MANAGER_gameover_OutHigh <= 1'b0;
            CC_LIVES_MANAGER_grace_OutHigh    <= 1'b0;
            CC_LIVES_MANAGER_lifelost_OutHigh <= 1'b0;
            CC_LIVES_MANAGER_low_OutHigh      <= LOW_AT_RESET;
        end else begin
            state                             <= stateNext;
            lives                             <= livesNext;
            graceCount                        <= graceCountNext;
            CC_LIVES_MANAGER_gameover_OutHigh <= (stateNext == OVER);
            CC_LIVES_MANAGER_grace_OutHigh    <= (stateNext == GRACE);
            CC_LIVES_MANAGER_lifelost_OutHigh <= lifelostNext;
            CC_LIVES_MANAGER_low_OutHigh      <= (livesNext != '0) && (livesNext <= LOW_LEVEL);
        end
    end

    assign CC_LIVES_MANAGER_lives_Out = lives;

endmodule

// File: tb/tb_cc_lives_manager.sv
// Directed self-checking bench for cc_lives_manager; bonus scenario built when LIVES_BONUS_EN is defined.
module tb_cc_lives_manager;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       restart = 1'b0;
    logic       death = 1'b0;
`ifdef LIVES_BONUS_EN
    logic       bonus = 1'b0;
`endif
    logic [2:0] lives;
    logic       gameover;
    logic       low;
    logic       grace;
    logic       lifelost;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    cc_lives_manager #(
        .LIVES_COUNTER_DATAWIDTH(3),
        .LIVES_INIT(3),
        .LIVES_MAX(7),
        .LIVES_LOW_THRESHOLD(1),
        .GRACE_CYCLES(16),
        .GRACE_DATAWIDTH(5)
    ) dut (
        .CC_LIVES_MANAGER_CLOCK_50(clk),
        .CC_LIVES_MANAGER_RESET_InHigh(rst),
        .CC_LIVES_MANAGER_restart_InHigh(restart),
        .CC_LIVES_MANAGER_death_InHigh(death),
`ifdef LIVES_BONUS_EN
        .CC_LIVES_MANAGER_bonus_InHigh(bonus),
`endif
        .CC_LIVES_MANAGER_lives_Out(lives),
        .CC_LIVES_MANAGER_gameover_OutHigh(gameover),
        .CC_LIVES_MANAGER_low_OutHigh(low),
        .CC_LIVES_MANAGER_grace_OutHigh(grace),
        .CC_LIVES_MANAGER_lifelost_OutHigh(lifelost)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        checks++; if (lives !== 3'd3) begin fails++; $display("FAIL reset_lives got %0d exp 3", lives); end
        checks++; if (gameover !== 1'b0) begin fails++; $display("FAIL reset_gameover got %b exp 0", gameover); end
        checks++; if (grace !== 1'b0) begin fails++; $display("FAIL reset_grace got %b exp 0", grace); end
        checks++; if (lifelost !== 1'b0) begin fails++; $display("FAIL reset_lifelost got %b exp 0", lifelost); end
        checks++; if (low !== 1'b0) begin fails++; $display("FAIL reset_low got %b exp 0", low); end
    endtask

    task automatic test_three_deaths();
        int lostSeen = 0;
        logic [2:0] expLives;
        doReset();
        for (int k = 0; k < 3; k++) begin
            checks++; if (gameover !== 1'b0) begin fails++; $display("FAIL pre_death%0d_gameover got %b exp 0", k, gameover); end
            death = 1'b1;
            tick();
            death = 1'b0;
            expLives = 3'(2 - k);
            if (lifelost === 1'b1) lostSeen++;
            checks++; if (lives !== expLives) begin fails++; $display("FAIL death%0d_lives got %0d exp %0d", k, lives, expLives); end
            checks++; if (lifelost !== 1'b1) begin fails++; $display("FAIL death%0d_lifelost got %b exp 1", k, lifelost); end
            checks++; if (low !== (expLives == 3'd1)) begin fails++; $display("FAIL death%0d_low got %b exp %b", k, low, expLives == 3'd1); end
            checks++; if (gameover !== (k == 2)) begin fails++; $display("FAIL death%0d_gameover got %b exp %b", k, gameover, k == 2); end
            checks++; if (grace !== (k != 2)) begin fails++; $display("FAIL death%0d_grace got %b exp %b", k, grace, k != 2); end
            for (int i = 0; i < 19; i++) begin
                tick();
                if (lifelost === 1'b1) lostSeen++;
            end
            checks++; if (grace !== 1'b0) begin fails++; $display("FAIL death%0d_grace_end got %b exp 0", k, grace); end
        end
        checks++; if (lostSeen != 3) begin fails++; $display("FAIL lifelost_count got %0d exp 3", lostSeen); end
        checks++; if (gameover !== 1'b1) begin fails++; $display("FAIL over_hold_gameover got %b exp 1", gameover); end
        checks++; if (lives !== 3'd0) begin fails++; $display("FAIL over_hold_lives got %0d exp 0", lives); end
    endtask

    task automatic test_grace_window();
        int graceCycles = 0;
        int lostSeen = 0;
        doReset();
        death = 1'b1;
        tick();
        death = 1'b0;
        if (grace === 1'b1) graceCycles++;
        if (lifelost === 1'b1) lostSeen++;
        for (int i = 1; i <= 30; i++) begin
            if (i == 5) death = 1'b1;
            tick();
            death = 1'b0;
            if (grace === 1'b1) graceCycles++;
            if (lifelost === 1'b1) lostSeen++;
            if (i == 15) begin
                checks++; if (grace !== 1'b1) begin fails++; $display("FAIL grace_last_cycle got %b exp 1", grace); end
            end
            if (i == 16) begin
                checks++; if (grace !== 1'b0) begin fails++; $display("FAIL grace_exit got %b exp 0", grace); end
            end
        end
        checks++; if (graceCycles != 16) begin fails++; $display("FAIL grace_length got %0d exp 16", graceCycles); end
        checks++; if (lostSeen != 1) begin fails++; $display("FAIL grace_death_ignored got %0d pulses exp 1", lostSeen); end
        checks++; if (lives !== 3'd2) begin fails++; $display("FAIL grace_lives got %0d exp 2", lives); end
    endtask

    task automatic test_restart_over();
        doReset();
        for (int k = 0; k < 3; k++) begin
            death = 1'b1;
            tick();
            death = 1'b0;
            for (int i = 0; i < 19; i++) tick();
        end
        checks++; if (gameover !== 1'b1) begin fails++; $display("FAIL over_reached got %b exp 1", gameover); end
        death = 1'b1;
        tick();
        death = 1'b0;
        checks++; if (lifelost !== 1'b0) begin fails++; $display("FAIL over_death_lifelost got %b exp 0", lifelost); end
        checks++; if (lives !== 3'd0) begin fails++; $display("FAIL over_death_lives got %0d exp 0", lives); end
        restart = 1'b1;
        death = 1'b1;
        tick();
        restart = 1'b0;
        death = 1'b0;
        checks++; if (lives !== 3'd3) begin fails++; $display("FAIL restart_lives got %0d exp 3", lives); end
        checks++; if (gameover !== 1'b0) begin fails++; $display("FAIL restart_gameover got %b exp 0", gameover); end
        checks++; if (lifelost !== 1'b0) begin fails++; $display("FAIL restart_lifelost got %b exp 0", lifelost); end
        checks++; if (grace !== 1'b0) begin fails++; $display("FAIL restart_grace got %b exp 0", grace); end
        death = 1'b1;
        tick();
        death = 1'b0;
        checks++; if (lifelost !== 1'b1 || lives !== 3'd2) begin fails++; $display("FAIL restart_play got lifelost=%b lives=%0d exp lifelost=1 lives=2", lifelost, lives); end
    endtask

    task automatic test_reset_mid_grace();
        doReset();
        death = 1'b1;
        tick();
        death = 1'b0;
        tick();
        tick();
        tick();
        checks++; if (grace !== 1'b1 || lives !== 3'd2) begin fails++; $display("FAIL pre_reset_grace got grace=%b lives=%0d exp grace=1 lives=2", grace, lives); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (lives !== 3'd3) begin fails++; $display("FAIL mid_reset_lives got %0d exp 3", lives); end
        checks++; if (grace !== 1'b0) begin fails++; $display("FAIL mid_reset_grace got %b exp 0", grace); end
        checks++; if (gameover !== 1'b0 || lifelost !== 1'b0) begin fails++; $display("FAIL mid_reset_flags got gameover=%b lifelost=%b exp 0 0", gameover, lifelost); end
        death = 1'b1;
        tick();
        death = 1'b0;
        checks++; if (lifelost !== 1'b1 || grace !== 1'b1) begin fails++; $display("FAIL mid_reset_play got lifelost=%b grace=%b exp 1 1", lifelost, grace); end
    endtask

`ifdef LIVES_BONUS_EN
    task automatic test_bonus();
        logic [2:0] expTable [6] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7};
        doReset();
        for (int i = 0; i < 6; i++) begin
            bonus = 1'b1;
            tick();
            bonus = 1'b0;
            checks++; if (lives !== expTable[i]) begin fails++; $display("FAIL bonus%0d_lives got %0d exp %0d", i, lives, expTable[i]); end
        end
        death = 1'b1;
        bonus = 1'b1;
        tick();
        death = 1'b0;
        bonus = 1'b0;
        checks++; if (lives !== 3'd7) begin fails++; $display("FAIL death_bonus_lives got %0d exp 7", lives); end
        checks++; if (grace !== 1'b1) begin fails++; $display("FAIL death_bonus_grace got %b exp 1", grace); end
        checks++; if (lifelost !== 1'b1) begin fails++; $display("FAIL death_bonus_lifelost got %b exp 1", lifelost); end
    endtask
`endif

    initial begin
        test_reset();
        test_three_deaths();
        test_grace_window();
        test_restart_over();
        test_reset_mid_grace();
`ifdef LIVES_BONUS_EN
        test_bonus();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
